// File: rtl/uart_bridge_sequencer.sv
// uart_bridge_sequencer
//   Sequences byte traffic between two TX requesters, an RX byte stream and a
//   UART bridge reached through an AXI4-Lite master port.
//   Bridge map: TXDATA 0x0 (write), RXDATA 0x4 (read),
//               STATUS 0x8 (bit0 tx_busy, bit1 rx_valid).
//   Build option: define UART_SEQ_RX_EN to enable RX polling and the rx_*
//   stream. Without it, rx_valid/rx_data are tied low, rx_ready is ignored and
//   STATUS is read only when a TX byte is pending.
// Ports:
//   clk, reset              sole clock, synchronous active-high reset
//   req0_*/req1_*           valid/ready TX byte streams from two requesters
//   rx_valid/rx_data/rx_ready  received-byte stream (held until rx_ready)
//   m_axi_*                 AXI4-Lite master towards the bridge slave port
//   err                     sticky flag, set on any non-OKAY BRESP/RRESP
module uart_bridge_sequencer #(
   parameter int unsigned AXI_ADDR_WIDTH = 32,
   parameter int unsigned AXI_DATA_WIDTH = 32,
   parameter int unsigned POLL_INTERVAL  = 16
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        req0_valid,
   input  logic [7:0]                  req0_data,
   output logic                        req0_ready,
   input  logic                        req1_valid,
   input  logic [7:0]                  req1_data,
   output logic                        req1_ready,
   output logic                        rx_valid,
   output logic [7:0]                  rx_data,
   input  logic                        rx_ready,
   output logic [AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
   output logic [2:0]                  m_axi_awprot,
   output logic                        m_axi_awvalid,
   input  logic                        m_axi_awready,
   output logic [AXI_DATA_WIDTH-1:0]   m_axi_wdata,
   output logic [AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
   output logic                        m_axi_wvalid,
   input  logic                        m_axi_wready,
   input  logic [1:0]                  m_axi_bresp,
   input  logic                        m_axi_bvalid,
   output logic                        m_axi_bready,
   output logic [AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
   output logic [2:0]                  m_axi_arprot,
   output logic                        m_axi_arvalid,
   input  logic                        m_axi_arready,
   input  logic [AXI_DATA_WIDTH-1:0]   m_axi_rdata,
   input  logic [1:0]                  m_axi_rresp,
   input  logic                        m_axi_rvalid,
   output logic                        m_axi_rready,
   output logic                        err
);

   localparam int unsigned STRB_W = AXI_DATA_WIDTH / 8;
   localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_TXDATA = AXI_ADDR_WIDTH'(32'h0);
   localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_STATUS = AXI_ADDR_WIDTH'(32'h8);

   // RX_HOLD is not a resting state: a received byte is held in the rx_valid /
   // rx_data output register while the FSM keeps serving TX traffic.
   typedef enum logic [2:0] {
      IDLE, ST_AR, ST_R, TX_AW, TX_B
`ifdef UART_SEQ_RX_EN
      , RX_AR, RX_R, RX_HOLD
`endif
   } state_t;

   state_t                      state, state_nxt;
   logic                        pending, pending_nxt;
   logic [7:0]                  tx_byte, tx_byte_nxt;
   logic                        gnt_id, gnt_id_nxt;      // owner of the pending byte
   logic                        last_gnt, last_gnt_nxt;  // 1 = requester 1
   logic                        req0_ready_nxt, req1_ready_nxt, err_nxt;
   logic [AXI_ADDR_WIDTH-1:0]   awaddr_nxt, araddr_nxt;
   logic [AXI_DATA_WIDTH-1:0]   wdata_nxt;
   logic                        awvalid_nxt, wvalid_nxt, bready_nxt, arvalid_nxt, rready_nxt;
   logic                        poll_due;
   logic                        rx_room;
   logic                        unused_in;

   assign m_axi_awprot = 3'b000;
   assign m_axi_arprot = 3'b000;
   assign m_axi_wstrb  = {STRB_W{1'b1}};

`ifdef UART_SEQ_RX_EN
   localparam int unsigned POLL_W = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
   localparam logic [POLL_W-1:0] POLL_RELOAD = POLL_W'(POLL_INTERVAL - 1);
   localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_RXDATA = AXI_ADDR_WIDTH'(32'h4);

   logic [POLL_W-1:0] poll_cnt, poll_cnt_nxt;
   logic              rx_valid_nxt;
   logic [7:0]        rx_data_nxt;

   assign poll_due  = (poll_cnt == '0);
   assign rx_room   = !rx_valid;
   assign unused_in = &{1'b0, m_axi_rdata};
`else
   assign poll_due  = 1'b0;
   assign rx_room   = 1'b0;
   assign rx_valid  = 1'b0;
   assign rx_data   = 8'h00;
   assign unused_in = &{1'b0, m_axi_rdata, rx_ready};
`endif

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         pending       <= 1'b0;
         tx_byte       <= '0;
         gnt_id        <= 1'b0;
         last_gnt      <= 1'b1;
         req0_ready    <= 1'b0;
         req1_ready    <= 1'b0;
         err           <= 1'b0;
         m_axi_awaddr  <= '0;
         m_axi_awvalid <= 1'b0;
         m_axi_wdata   <= '0;
         m_axi_wvalid  <= 1'b0;
         m_axi_bready  <= 1'b0;
         m_axi_araddr  <= '0;
         m_axi_arvalid <= 1'b0;
         m_axi_rready  <= 1'b0;
`ifdef UART_SEQ_RX_EN
         poll_cnt      <= POLL_RELOAD;
         rx_valid      <= 1'b0;
         rx_data       <= '0;
`endif
      end else begin
         state         <= state_nxt;
         pending       <= pending_nxt;
         tx_byte       <= tx_byte_nxt;
         gnt_id        <= gnt_id_nxt;
         last_gnt      <= last_gnt_nxt;
         req0_ready    <= req0_ready_nxt;
         req1_ready    <= req1_ready_nxt;
         err           <= err_nxt;
         m_axi_awaddr  <= awaddr_nxt;
         m_axi_awvalid <= awvalid_nxt;
         m_axi_wdata   <= wdata_nxt;
         m_axi_wvalid  <= wvalid_nxt;
         m_axi_bready  <= bready_nxt;
         m_axi_araddr  <= araddr_nxt;
         m_axi_arvalid <= arvalid_nxt;
         m_axi_rready  <= rready_nxt;
`ifdef UART_SEQ_RX_EN
         poll_cnt      <= poll_cnt_nxt;
         rx_valid      <= rx_valid_nxt;
         rx_data       <= rx_data_nxt;
`endif
      end
   end

   // Next-state and output decode
   always_comb begin
      state_nxt      = state;
      pending_nxt    = pending;
      tx_byte_nxt    = tx_byte;
      gnt_id_nxt     = gnt_id;
      last_gnt_nxt   = last_gnt;
      req0_ready_nxt = 1'b0;
      req1_ready_nxt = 1'b0;
      err_nxt        = err;
      awaddr_nxt     = m_axi_awaddr;
      awvalid_nxt    = m_axi_awvalid;
      wdata_nxt      = m_axi_wdata;
      wvalid_nxt     = m_axi_wvalid;
      bready_nxt     = m_axi_bready;
      araddr_nxt     = m_axi_araddr;
      arvalid_nxt    = m_axi_arvalid;
      rready_nxt     = m_axi_rready;
`ifdef UART_SEQ_RX_EN
      poll_cnt_nxt   = poll_cnt;
      rx_valid_nxt   = rx_valid;
      rx_data_nxt    = rx_data;
      if (rx_valid && rx_ready) rx_valid_nxt = 1'b0;
`endif

      case (state)
         IDLE: begin
`ifdef UART_SEQ_RX_EN
            if (!pending && !poll_due) poll_cnt_nxt = poll_cnt - POLL_W'(1);
`endif
            // Ready pulse cycle: the byte is taken on the handshake edge
            if (req0_ready || req1_ready) begin
               if (req0_ready && req0_valid) begin
                  tx_byte_nxt = req0_data;
                  gnt_id_nxt  = 1'b0;
                  pending_nxt = 1'b1;
               end else if (req1_ready && req1_valid) begin
                  tx_byte_nxt = req1_data;
                  gnt_id_nxt  = 1'b1;
                  pending_nxt = 1'b1;
               end
            end else if (!pending && (req0_valid || req1_valid)) begin
               if (req0_valid && (!req1_valid || last_gnt)) req0_ready_nxt = 1'b1;
               else                                         req1_ready_nxt = 1'b1;
            end else if (pending || poll_due) begin
               state_nxt   = ST_AR;
               araddr_nxt  = ADDR_STATUS;
               arvalid_nxt = 1'b1;
            end
         end
         ST_AR: begin
            if (m_axi_arready) begin
               arvalid_nxt = 1'b0;
               rready_nxt  = 1'b1;
               state_nxt   = ST_R;
            end
         end
         ST_R: begin
            if (m_axi_rvalid) begin
               rready_nxt = 1'b0;
`ifdef UART_SEQ_RX_EN
               poll_cnt_nxt = POLL_RELOAD;
`endif
               if (m_axi_rresp != 2'b00) begin
                  // Failed STATUS read drops any pending byte
                  err_nxt     = 1'b1;
                  pending_nxt = 1'b0;
                  if (pending) last_gnt_nxt = gnt_id;
                  state_nxt   = IDLE;
               end else if (m_axi_rdata[1] && rx_room) begin
`ifdef UART_SEQ_RX_EN
                  araddr_nxt  = ADDR_RXDATA;
                  arvalid_nxt = 1'b1;
                  state_nxt   = RX_AR;
`endif
               end else if (pending && !m_axi_rdata[0]) begin
                  awaddr_nxt  = ADDR_TXDATA;
                  wdata_nxt   = AXI_DATA_WIDTH'(tx_byte);
                  awvalid_nxt = 1'b1;
                  wvalid_nxt  = 1'b1;
                  state_nxt   = TX_AW;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         TX_AW: begin
            if (m_axi_awvalid && m_axi_awready) awvalid_nxt = 1'b0;
            if (m_axi_wvalid && m_axi_wready)   wvalid_nxt  = 1'b0;
            if ((!m_axi_awvalid || m_axi_awready) && (!m_axi_wvalid || m_axi_wready)) begin
               bready_nxt = 1'b1;
               state_nxt  = TX_B;
            end
         end
         TX_B: begin
            if (m_axi_bvalid) begin
               bready_nxt   = 1'b0;
               if (m_axi_bresp != 2'b00) err_nxt = 1'b1;
               pending_nxt  = 1'b0;
               last_gnt_nxt = gnt_id;
               state_nxt    = IDLE;
            end
         end
`ifdef UART_SEQ_RX_EN
         RX_AR: begin
            if (m_axi_arready) begin
               arvalid_nxt = 1'b0;
               rready_nxt  = 1'b1;
               state_nxt   = RX_R;
            end
         end
         RX_R: begin
            if (m_axi_rvalid) begin
               rready_nxt = 1'b0;
               if (m_axi_rresp != 2'b00) begin
                  err_nxt = 1'b1;
               end else begin
                  rx_valid_nxt = 1'b1;
                  rx_data_nxt  = m_axi_rdata[7:0];
               end
               state_nxt = IDLE;
            end
         end
`endif
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_uart_bridge_sequencer.sv
// tb_uart_bridge_sequencer
//   Directed bench for uart_bridge_sequencer with a small reactive AXI4-Lite
//   bridge model (STATUS busy/error/rx knobs, write log, B-response hold).
//   RX steps are compiled only when UART_SEQ_RX_EN is defined.
module tb_uart_bridge_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        req0_valid, req0_ready, req1_valid, req1_ready;
   logic [7:0]  req0_data, req1_data;
   logic        rx_valid, rx_ready;
   logic [7:0]  rx_data;
   logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
   logic [2:0]  m_axi_awprot, m_axi_arprot;
   logic [3:0]  m_axi_wstrb;
   logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
   logic [1:0]  m_axi_bresp, m_axi_rresp;
   logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
   logic        m_axi_rvalid, m_axi_rready, err;

   always #5 clk = ~clk;

   uart_bridge_sequencer #(
      .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32), .POLL_INTERVAL(16)
   ) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
      .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
      .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
      .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
      .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
      .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
      .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
      .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
      .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
      .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
      .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
      .err(err)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Bridge model state: counters owned by the model, knobs owned by the stimulus
   int          st_reads = 0, rx_reads = 0, bad_reads = 0;
   int          wr_count = 0, aw_hs = 0, w_hs = 0;
   int          busy_until, err_at, rx_arrivals;
   logic        b_hold, b_due;
   logic [7:0]  rx_bytes [8];
   logic [31:0] wr_addr_log [64];
   logic [31:0] wr_data_log [64];

   // Protocol watch on the requester ready pulses
   int   viol = 0, p0_count = 0;
   logic r0_prev = 1'b0;

   int st_mark, wr_mark, rx_mark, p0_mark, wr_snap;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   always @(posedge clk) begin
      if (reset) begin
         m_axi_rvalid <= 1'b0;
         m_axi_bvalid <= 1'b0;
         b_due        <= 1'b0;
      end else begin
         if (m_axi_arvalid && m_axi_arready) begin
            m_axi_rvalid <= 1'b1;
            m_axi_rresp  <= 2'b00;
            m_axi_rdata  <= 32'h0;
            if (m_axi_araddr == 32'h8) begin
               m_axi_rdata <= {30'h0, rx_arrivals > rx_reads, st_reads < busy_until};
               if (st_reads == err_at) m_axi_rresp <= 2'b10;
               st_reads <= st_reads + 1;
            end else if (m_axi_araddr == 32'h4) begin
               m_axi_rdata <= {24'h0, rx_bytes[rx_reads % 8]};
               rx_reads    <= rx_reads + 1;
            end else begin
               bad_reads <= bad_reads + 1;
            end
         end else if (m_axi_rvalid && m_axi_rready) begin
            m_axi_rvalid <= 1'b0;
         end
         if (m_axi_awvalid && m_axi_awready) aw_hs <= aw_hs + 1;
         if (m_axi_wvalid && m_axi_wready)   w_hs  <= w_hs + 1;
         if (m_axi_awvalid && m_axi_awready && m_axi_wvalid && m_axi_wready) begin
            wr_addr_log[wr_count % 64] <= m_axi_awaddr;
            wr_data_log[wr_count % 64] <= m_axi_wdata;
            wr_count <= wr_count + 1;
            b_due    <= 1'b1;
         end
         if (b_due && !b_hold && !m_axi_bvalid) begin
            m_axi_bvalid <= 1'b1;
            m_axi_bresp  <= 2'b00;
            b_due        <= 1'b0;
         end else if (m_axi_bvalid && m_axi_bready) begin
            m_axi_bvalid <= 1'b0;
         end
      end
   end

   always @(posedge clk) begin
      r0_prev <= req0_ready;
      if (req0_ready) p0_count <= p0_count + 1;
      if (!reset) begin
         if ((req0_ready || req1_ready) &&
             (m_axi_arvalid || m_axi_awvalid || m_axi_wvalid || m_axi_bready || m_axi_rready))
            viol <= viol + 1;
         if (req0_ready && req1_ready) viol <= viol + 1;
         if (req0_ready && r0_prev)    viol <= viol + 1;
      end
   end

   // Offer one byte, wait for the ready pulse, arm the bridge knobs for this byte
   task automatic send(input bit which, input logic [7:0] b, input int busy, input bit st_err);
      bit got = 1'b0;
      @(negedge clk);
      if (which) begin req1_valid = 1'b1; req1_data = b; end
      else       begin req0_valid = 1'b1; req0_data = b; end
      for (int c = 0; c < 60 && !got; c++) begin
         @(negedge clk);
         if (which ? req1_ready : req0_ready) got = 1'b1;
      end
      check("grant", 32'(got), 32'd1);
      busy_until = st_reads + busy;
      err_at     = st_err ? st_reads : -1;
      st_mark    = st_reads;
      wr_mark    = wr_count;
      @(posedge clk); #1;
      if (which) req1_valid = 1'b0; else req0_valid = 1'b0;
   endtask

   task automatic wait_write(input int n, input string tag);
      int c = 0;
      while (wr_count < n && c < 200) begin @(negedge clk); c++; end
      check(tag, 32'(wr_count >= n), 32'd1);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic g0, g1, seen;
      reset = 1'b1;
      req0_valid = 1'b0; req1_valid = 1'b0; req0_data = 8'h0; req1_data = 8'h0;
      rx_ready = 1'b0; b_hold = 1'b0; busy_until = 0; err_at = -1; rx_arrivals = 0;
      m_axi_awready = 1'b1; m_axi_wready = 1'b1; m_axi_arready = 1'b1;
      for (int i = 0; i < 8; i++) rx_bytes[i] = 8'h00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_ctrl", 32'({req0_ready, req1_ready, rx_valid, err, m_axi_awvalid,
                               m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}), 32'd0);
      check("reset_araddr", m_axi_araddr, 32'h0);
      check("reset_awaddr_wdata", m_axi_awaddr | m_axi_wdata, 32'h0);
      check("reset_rx_data", 32'(rx_data), 32'h0);
      check("prot_strb", 32'({m_axi_awprot, m_axi_arprot, m_axi_wstrb}), 32'h0000000F);
      reset = 1'b0;

      // Idle behaviour: polls only with RX enabled
      repeat (40) @(negedge clk);
`ifdef UART_SEQ_RX_EN
      check("idle_polls", 32'(st_reads > 0), 32'd1);
`else
      check("idle_no_status", 32'(st_reads), 32'd0);
`endif

      // Tie after reset: requester 0 first, then grants alternate
      wr_mark = wr_count;
      req0_data = 8'h11; req1_data = 8'h22; req0_valid = 1'b1; req1_valid = 1'b1;
      for (int c = 0; c < 400 && wr_count < wr_mark + 4; c++) begin
         @(negedge clk);
         g0 = req0_ready; g1 = req1_ready;
         if (g0 || g1) begin
            @(posedge clk); #1;
            if (g0) begin if (req0_data == 8'h11) req0_data = 8'h33; else req0_valid = 1'b0; end
            if (g1) begin if (req1_data == 8'h22) req1_data = 8'h44; else req1_valid = 1'b0; end
         end
      end
      check("rr_count", 32'(wr_count - wr_mark), 32'd4);
      check("rr_1st", wr_data_log[(wr_mark + 0) % 64], 32'h11);
      check("rr_2nd", wr_data_log[(wr_mark + 1) % 64], 32'h22);
      check("rr_3rd", wr_data_log[(wr_mark + 2) % 64], 32'h33);
      check("rr_4th", wr_data_log[(wr_mark + 3) % 64], 32'h44);
      repeat (4) @(negedge clk);

      // Single byte: one STATUS read, one write of 0x000000A5
      p0_mark = p0_count;
      send(1'b0, 8'hA5, 0, 1'b0);
      wait_write(wr_mark + 1, "a5_write_timeout");
      check("a5_status_reads", 32'(st_reads - st_mark), 32'd1);
      check("a5_awaddr", wr_addr_log[wr_mark % 64], 32'h0);
      check("a5_wdata", wr_data_log[wr_mark % 64], 32'h000000A5);
      repeat (4) @(negedge clk);
      check("a5_ready_pulses", 32'(p0_count - p0_mark), 32'd1);
      check("a5_err", 32'(err), 32'd0);

      // tx_busy for three polls: four STATUS reads, one write
      send(1'b0, 8'hC3, 3, 1'b0);
      wait_write(wr_mark + 1, "busy_write_timeout");
      check("busy_status_reads", 32'(st_reads - st_mark), 32'd4);
      check("busy_wdata", wr_data_log[wr_mark % 64], 32'h000000C3);
      repeat (4) @(negedge clk);
      check("busy_one_write", 32'(wr_count - wr_mark), 32'd1);

`ifdef UART_SEQ_RX_EN
      // Received byte held until consumed, no further RXDATA read meanwhile
      rx_mark = rx_reads;
      rx_bytes[rx_arrivals % 8] = 8'h5A; rx_arrivals = rx_arrivals + 1;
      seen = 1'b0;
      for (int c = 0; c < 100 && !seen; c++) begin @(negedge clk); seen = rx_valid; end
      check("rx_valid_5a", 32'(rx_valid), 32'd1);
      check("rx_data_5a", 32'(rx_data), 32'h5A);
      check("rx_reads_1", 32'(rx_reads - rx_mark), 32'd1);
      rx_bytes[rx_arrivals % 8] = 8'h6B; rx_arrivals = rx_arrivals + 1;
      repeat (80) @(negedge clk);
      check("rx_hold_valid", 32'(rx_valid), 32'd1);
      check("rx_hold_data", 32'(rx_data), 32'h5A);
      check("rx_hold_no_read", 32'(rx_reads - rx_mark), 32'd1);
      rx_ready = 1'b1;
      @(negedge clk); rx_ready = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 100 && !seen; c++) begin @(negedge clk); seen = rx_valid; end
      check("rx_data_6b", 32'(rx_data), 32'h6B);
      check("rx_reads_2", 32'(rx_reads - rx_mark), 32'd2);
      rx_ready = 1'b1;
      @(negedge clk); rx_ready = 1'b0;
      check("rx_consumed", 32'(rx_valid), 32'd0);
`endif

      // STATUS error: err sticky, byte dropped, FSM still serves requests
      send(1'b0, 8'h3C, 0, 1'b1);
      repeat (20) @(negedge clk);
      check("st_err_set", 32'(err), 32'd1);
      check("st_err_no_write", 32'(wr_count - wr_mark), 32'd0);
      repeat (30) @(negedge clk);
      check("st_err_sticky", 32'(err), 32'd1);
      send(1'b0, 8'h5C, 0, 1'b0);
      wait_write(wr_mark + 1, "after_err_write_timeout");
      check("after_err_wdata", wr_data_log[wr_mark % 64], 32'h5C);
      repeat (4) @(negedge clk);

      // Reset while waiting in TX_B with a requester 1 byte pending
      b_hold = 1'b1;
      send(1'b1, 8'h77, 0, 1'b0);
      seen = 1'b0;
      for (int c = 0; c < 50 && !seen; c++) begin @(negedge clk); seen = m_axi_bready; end
      check("txb_reached", 32'(seen), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      check("midrst_ctrl", 32'({req0_ready, req1_ready, rx_valid, err, m_axi_awvalid,
                                m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}), 32'd0);
      check("midrst_addr_data", m_axi_araddr | m_axi_awaddr | m_axi_wdata, 32'h0);
      reset = 1'b0;
      b_hold = 1'b0;
      wr_snap = wr_count;
      repeat (60) @(negedge clk);
      check("midrst_no_write", 32'(wr_count - wr_snap), 32'd0);

      check("aw_handshakes", 32'(aw_hs), 32'(wr_count));
      check("w_handshakes", 32'(w_hs), 32'(wr_count));
      check("bad_reads", 32'(bad_reads), 32'd0);
      check("ready_protocol", 32'(viol), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_bridge_sequencer.md
UART_BRIDGE_SEQUENCER -- requirements
Module: uart_bridge_sequencer

Interface
REQ-001 SHALL have parameter AXI_ADDR_WIDTH, default 32, master address width.
REQ-002 SHALL have parameter AXI_DATA_WIDTH, default 32, master data width.
REQ-003 SHALL have parameter POLL_INTERVAL, default 16, idle cycles between RX STATUS polls (>=1).
REQ-004 SHALL have ports:
- clk  in  1  sole clock.
- reset  in  1  synchronous, active-high reset.
- req0_valid/req0_data/req0_ready  in/in/out  1/8/1  requester 0 TX byte stream.
- req1_valid/req1_data/req1_ready  in/in/out  1/8/1  requester 1 TX byte stream.
- rx_valid/rx_data/rx_ready  out/out/in  1/8/1  received-byte stream.
- m_axi_aw*/w*/b*/ar*/r*  AXI4-Lite master; standard widths; connects to the bridge slave port.
- err  out  1  sticky flag, set on any non-OKAY BRESP/RRESP.

Function
REQ-005 SHALL use bridge map: TXDATA 0x0 (write), RXDATA 0x4 (read), STATUS 0x8 (bit0 tx_busy, bit1 rx_valid).
REQ-006 SHALL run FSM states IDLE, ST_AR, ST_R, TX_AW, TX_B, RX_AR, RX_R, RX_HOLD.
REQ-007 IDLE, no byte pending, some reqN_valid: grant round-robin (requester not last granted wins on tie); pulse reqN_ready 1 cycle, latch byte, set pending.
REQ-008 IDLE, pending, or RX poll counter expired: go ST_AR, araddr=0x8, arvalid held until arready.
REQ-009 ST_R: rready=1; on rvalid capture STATUS.
REQ-010 After STATUS: rx_valid=1 and RX_HOLD empty -> RX_AR (RX priority over TX); else pending and tx_busy=0 -> TX_AW; else IDLE.
REQ-011 TX_AW: awaddr=0x0, wdata={zeros,byte}; awvalid and wvalid asserted same cycle, each dropped independently on own ready; both done -> TX_B.
REQ-012 TX_B: bready=1; on bvalid clear pending, record last granted, -> IDLE.
REQ-013 RX_AR/RX_R: read 0x4; on rvalid latch rdata[7:0], assert rx_valid, -> IDLE.
REQ-014 rx_valid SHALL hold with stable rx_data until rx_ready; no further RXDATA read while held.
REQ-015 Poll counter SHALL count IDLE cycles with no pending byte, reload to POLL_INTERVAL-1 on each STATUS read.
REQ-016 Non-OKAY response SHALL set err; transaction still completes (byte dropped, pending cleared).
REQ-017 At most one AXI transaction outstanding; araddr/awaddr/wdata stable while valid.
REQ-018 reqN_ready SHALL never assert while pending set or FSM not IDLE.

Reset
REQ-019 reset SHALL force IDLE; all valid/ready outputs, err, rx_valid, pending =0; addresses/data =0; last granted = requester 1 (requester 0 wins first tie); poll counter = POLL_INTERVAL-1.
REQ-020 reset mid-transaction SHALL abandon it immediately; no completion after release.

Configuration
REQ-021 Macro UART_SEQ_RX_EN defined: RX polling, RX states, rx_* stream as above.
REQ-022 Undefined: no poll counter, no RX_AR/RX_R/RX_HOLD, rx_valid tied 0, rx_data 0, rx_ready ignored; STATUS read only when pending.

Verification
REQ-023 req0 byte 0xA5, bridge idle -> one STATUS read, then write 0x0 data 0x000000A5, req0_ready pulses once, err=0.
REQ-024 req0 and req1 valid together (0x11, 0x22) after reset -> 0x11 written first, then 0x22; repeat -> order alternates.
REQ-025 STATUS tx_busy=1 for 3 polls then 0 -> 4 STATUS reads, exactly one TXDATA write.
REQ-026 UART_SEQ_RX_EN, serial byte 0x5A arrives, rx_ready=0 -> rx_valid=1 rx_data=0x5A held; no second RXDATA read until rx_ready=1.
REQ-027 Slave returns RRESP=2 on STATUS -> err=1 and stays 1 until reset; FSM returns IDLE.
REQ-028 reset asserted during TX_B with req1 pending -> all outputs reset values next cycle; no write issued after release without new request.
